// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and types.
// Multiplier and butterfly stages must agree on these defaults.
package ntt_pkg;

    localparam int NTT_DATA_WIDTH = 22;
    localparam int NTT_MODULUS    = 4194301;
    localparam int NTT_MUL_LAT    = 3;
    localparam int NTT_FRAME_LEN  = 16384;

    typedef logic [NTT_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/bf_addsub_mod_if.sv
// Butterfly back-end stream bundle.
// Ports: in_valid/a_in/byp_in/bw_in from upstream,
//        out_valid/x_out/y_out/out_last to the next radix stage.
interface bf_addsub_mod_if
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = NTT_DATA_WIDTH
);

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] a_in;
    logic                  byp_in;
    logic [DATA_WIDTH-1:0] bw_in;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] x_out;
    logic [DATA_WIDTH-1:0] y_out;
    logic                  out_last;

    modport master (
        output in_valid, a_in, byp_in, bw_in,
        input  out_valid, x_out, y_out, out_last
    );

    modport slave (
        input  in_valid, a_in, byp_in, bw_in,
        output out_valid, x_out, y_out, out_last
    );

endinterface

// File: rtl/addsub_mod.sv
// Combinational modular add/sub: x=(a+bw) mod P, y=(a-bw) mod P.
// Ports: a, bw in (both < P); x, y out.
module addsub_mod
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = NTT_DATA_WIDTH,
    parameter int MODULUS    = NTT_MODULUS
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] bw,
    output logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y
);

    localparam logic [DATA_WIDTH:0] P_EXT = (DATA_WIDTH+1)'(MODULUS);

    logic [DATA_WIDTH:0] s;
    logic [DATA_WIDTH:0] d;

    always_comb begin
        s = {1'b0, a} + {1'b0, bw};
        d = {1'b0, a} - {1'b0, bw};
        x = (s >= P_EXT) ? DATA_WIDTH'(s - P_EXT) : DATA_WIDTH'(s);
        // a < bw: d wrapped past zero, adding P brings it back into range
        y = (a >= bw) ? DATA_WIDTH'(d) : DATA_WIDTH'(d + P_EXT);
    end

endmodule

// File: rtl/bf_addsub_mod.sv
// NTT butterfly back-end: aligns a with the multiplier product,
// outputs registered (a+bw, a-bw) mod P with valid/last framing.
// Ports: clk, rst_n (async, active-high), bus (slave side of stream).
module bf_addsub_mod
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = NTT_DATA_WIDTH,
    parameter int MODULUS    = NTT_MODULUS,
    parameter int MUL_LAT    = NTT_MUL_LAT,
    parameter int FRAME_LEN  = NTT_FRAME_LEN
) (
    input  logic           clk,
    input  logic           rst_n,
    bf_addsub_mod_if.slave bus
);

    if (MUL_LAT < 1) begin : g_bad_lat
        $error("MUL_LAT must be >= 1");
    end
    if (FRAME_LEN < 1) begin : g_bad_frame
        $error("FRAME_LEN must be >= 1");
    end

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);

    // Delay line: stage MUL_LAT-1 is the one that meets bw_in
    logic [MUL_LAT-1:0]    dl_valid_q, dl_valid_d;
    logic [MUL_LAT-1:0]    dl_byp_q, dl_byp_d;
    logic [DATA_WIDTH-1:0] dl_a_q [MUL_LAT];
    logic [DATA_WIDTH-1:0] dl_a_d [MUL_LAT];

    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  tail_valid;
    logic                  tail_byp;
    logic [DATA_WIDTH-1:0] tail_a;
    logic [DATA_WIDTH-1:0] sum_x;
    logic [DATA_WIDTH-1:0] dif_y;

    assign tail_valid = dl_valid_q[MUL_LAT-1];
    assign tail_byp   = dl_byp_q[MUL_LAT-1];
    assign tail_a     = dl_a_q[MUL_LAT-1];

    addsub_mod #(
        .DATA_WIDTH (DATA_WIDTH),
        .MODULUS    (MODULUS)
    ) u_addsub (
        .a  (tail_a),
        .bw (bus.bw_in),
        .x  (sum_x),
        .y  (dif_y)
    );

    always_comb begin
        dl_valid_d[0] = bus.in_valid;
        dl_byp_d[0]   = bus.in_valid ? bus.byp_in : dl_byp_q[0];
        dl_a_d[0]     = bus.in_valid ? bus.a_in : dl_a_q[0];
        for (int k = 1; k < MUL_LAT; k++) begin
            dl_valid_d[k] = dl_valid_q[k-1];
            // Data only moves with a valid sample; bubbles leave it parked
            dl_byp_d[k]   = dl_valid_q[k-1] ? dl_byp_q[k-1] : dl_byp_q[k];
            dl_a_d[k]     = dl_valid_q[k-1] ? dl_a_q[k-1] : dl_a_q[k];
        end
    end

    always_comb begin
        out_valid_d = tail_valid;
        out_last_d  = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        if (tail_valid) begin
            x_d        = tail_byp ? tail_a : sum_x;
            y_d        = tail_byp ? bus.bw_in : dif_y;
            out_last_d = (cnt_q == CNT_MAX);
            cnt_d      = out_last_d ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dl_valid_q  <= '0;
            dl_byp_q    <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                dl_a_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
        end else begin
            dl_valid_q  <= dl_valid_d;
            dl_byp_q    <= dl_byp_d;
            for (int k = 0; k < MUL_LAT; k++) begin
                dl_a_q[k] <= dl_a_d[k];
            end
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;

endmodule

// File: tb/tb_bf_addsub_mod.sv
// Directed bench for bf_addsub_mod (P=4194301, MUL_LAT=3, FRAME_LEN=4).
// Drives and samples on the falling edge; bw is issued 3 cycles after a.
module tb_bf_addsub_mod;

    localparam int DW = 22;
    localparam int P  = 4194301;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    bf_addsub_mod_if #(.DATA_WIDTH(DW)) bus ();

    bf_addsub_mod #(
        .DATA_WIDTH (DW),
        .MODULUS    (P),
        .MUL_LAT    (3),
        .FRAME_LEN  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit v;
        bit byp;
        int a;
        int bw;
        int x;
        int y;
        bit last;
    } smp_t;

    smp_t hist[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hx    = 0;
    int   hy    = 0;

    task automatic chk(string tag, logic [31:0] got, int exp);
        n_cmp++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic verify(smp_t s);
        chk("out_valid", 32'(bus.out_valid), int'(s.v));
        if (s.v) begin
            chk("x_out", 32'(bus.x_out), s.x);
            chk("y_out", 32'(bus.y_out), s.y);
            chk("out_last", 32'(bus.out_last), int'(s.last));
            hx = s.x;
            hy = s.y;
        end else begin
            chk("last_bubble", 32'(bus.out_last), 0);
            chk("x_hold", 32'(bus.x_out), hx);
            chk("y_hold", 32'(bus.y_out), hy);
        end
    endtask

    task automatic step(bit v, bit byp, int a, int bw, int x, int y, bit last);
        smp_t s;
        int   n;
        s = '{v, byp, a, bw, x, y, last};
        @(negedge clk);
        hist.push_back(s);
        n = hist.size();
        if (n >= 5) verify(hist[n-5]);
        bus.bw_in    = (n >= 4) ? DW'(hist[n-4].bw) : '0;
        bus.in_valid = v;
        bus.byp_in   = byp;
        bus.a_in     = DW'(a);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic pulse_reset();
        smp_t b;
        b = '{1'b0, 1'b0, 0, 0, 0, 0, 1'b0};
        @(negedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.byp_in   = 1'b0;
        bus.a_in     = '0;
        bus.bw_in    = '0;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_last", 32'(bus.out_last), 0);
        chk("rst_x", 32'(bus.x_out), 0);
        chk("rst_y", 32'(bus.y_out), 0);
        @(negedge clk);
        chk("rst_valid2", 32'(bus.out_valid), 0);
        rst_n = 1'b0;
        hist.delete();
        repeat (4) hist.push_back(b);
        hx = 0;
        hy = 0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.byp_in   = 1'b0;
        bus.a_in     = '0;
        bus.bw_in    = '0;
        pulse_reset();

        // basic, then isolated by bubbles so only one valid appears
        step(1, 0, 5, 3, 8, 2, 0);
        repeat (4) bubble();
        // sum wrap, negative diff, equal operands (4th output -> last)
        step(1, 0, 4194300, 10, 9, 4194290, 0);
        step(1, 0, 3, 10, 13, 4194294, 0);
        step(1, 0, 7, 7, 14, 0, 1);
        // bypass: no reduction of bw
        step(1, 1, 100, 4194300, 100, 4194300, 0);
        repeat (5) bubble();

        // 8 samples with a 2-cycle bubble after the 3rd
        pulse_reset();
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) repeat (2) bubble();
            step(1, 0, i, 2 * i, 3 * i, P - i, (i == 4) || (i == 8));
        end
        repeat (5) bubble();

        // reset with two samples in flight; they must never appear
        step(1, 0, 50, 1, 51, 49, 0);
        step(1, 0, 60, 2, 62, 58, 0);
        pulse_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 10 + i, i, 10 + 2 * i, 10, i == 4);
        end
        repeat (5) bubble();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
